// File: rtl/cprv_hazard_pkg.sv
// Shared opcode constants and hazard FSM state encoding for the CPRV pipeline
// control logic (hazard detection and forwarding).
package cprv_hazard_pkg;

    localparam logic [6:0] LOAD      = 7'b0000011;
    localparam logic [6:0] STORE     = 7'b0100011;
    localparam logic [6:0] OP        = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_32     = 7'b0111011;
    localparam logic [6:0] OP_IMM_32 = 7'b0011011;

    typedef enum logic [1:0] {
        HZ_RUN      = 2'd0,
        HZ_LU_HOLD  = 2'd1,
        HZ_MEM_WAIT = 2'd2
    } hz_state_t;

    function automatic logic is_mem_op(input logic [6:0] opc);
        return (opc == LOAD) || (opc == STORE);
    endfunction

endpackage

// File: rtl/cprv_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module cprv_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_en,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc_en && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/cprv_hazard_unit.sv
// Load-use and data-memory-wait hazard control for the CPRV pipeline.
// Optional performance counters are built when CPRV_HAZARD_PERF_EN is defined.
//
// state       | meaning
// HZ_RUN      | no hazard in progress
// HZ_LU_HOLD  | second bubble of a load-use stall
// HZ_MEM_WAIT | pipeline frozen on data memory; lu_pend = a load-use bubble is still owed
module cprv_hazard_unit
    import cprv_hazard_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_id,
    input  logic [4:0]  rs1_addr_id,
    input  logic [4:0]  rs2_addr_id,
    input  logic        rs1_used_id,
    input  logic        rs2_used_id,
    input  logic [6:0]  opcode_ex,
    input  logic [4:0]  rd_addr_ex,
    input  logic        rd_en_ex,
    input  logic [6:0]  opcode_mem,
    input  logic        dmem_ready,
    output logic        stall_if,
    output logic        stall_id,
    output logic        stall_ex,
    output logic        stall_mem,
    output logic        bubble_ex,
    output logic [1:0]  hz_state
`ifdef CPRV_HAZARD_PERF_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [15:0] lu_events
`endif
);

    if (DATA_WIDTH % 32 != 0) begin : g_width_check
        $error("cprv_hazard_unit: DATA_WIDTH must be a multiple of 32");
    end

    hz_state_t state_q, state_d;
    logic      lu_pend_q, lu_pend_d;
    logic      lu_hit;
    logic      mem_wait;
    logic      rs1_match;
    logic      rs2_match;

    assign rs1_match = rs1_used_id && (rs1_addr_id == rd_addr_ex);
    assign rs2_match = rs2_used_id && (rs2_addr_id == rd_addr_ex);

    assign lu_hit = valid_id && (opcode_ex == LOAD) && rd_en_ex &&
                    (rd_addr_ex != 5'd0) && (rs1_match || rs2_match);

    assign mem_wait = is_mem_op(opcode_mem) && !dmem_ready;

    always_comb begin
        state_d   = state_q;
        lu_pend_d = lu_pend_q;
        stall_if  = 1'b0;
        stall_id  = 1'b0;
        stall_ex  = 1'b0;
        stall_mem = 1'b0;
        bubble_ex = 1'b0;

        if (rst) begin
            state_d   = HZ_RUN;
            lu_pend_d = 1'b0;
        end else if (mem_wait) begin
            // Memory freeze overrides any load-use bubble; a bubble owed from
            // LU_HOLD is remembered in lu_pend and issued when memory completes.
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            stall_ex  = 1'b1;
            stall_mem = 1'b1;
            case (state_q)
                HZ_RUN: begin
                    state_d   = HZ_MEM_WAIT;
                    lu_pend_d = 1'b0;
                end
                HZ_LU_HOLD: begin
                    state_d   = HZ_MEM_WAIT;
                    lu_pend_d = 1'b1;
                end
                default: state_d = HZ_MEM_WAIT;
            endcase
        end else begin
            case (state_q)
                HZ_LU_HOLD: begin
                    stall_if  = 1'b1;
                    stall_id  = 1'b1;
                    bubble_ex = 1'b1;
                    state_d   = HZ_RUN;
                end
                HZ_MEM_WAIT: begin
                    lu_pend_d = 1'b0;
                    if (lu_pend_q) begin
                        stall_if  = 1'b1;
                        stall_id  = 1'b1;
                        bubble_ex = 1'b1;
                        state_d   = HZ_RUN;
                    end else if (lu_hit) begin
                        stall_if  = 1'b1;
                        stall_id  = 1'b1;
                        bubble_ex = 1'b1;
                        state_d   = HZ_LU_HOLD;
                    end else begin
                        state_d   = HZ_RUN;
                    end
                end
                default: begin
                    if (lu_hit) begin
                        stall_if  = 1'b1;
                        stall_id  = 1'b1;
                        bubble_ex = 1'b1;
                        state_d   = HZ_LU_HOLD;
                    end else begin
                        state_d   = HZ_RUN;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= HZ_RUN;
            lu_pend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            lu_pend_q <= lu_pend_d;
        end
    end

    assign hz_state = rst ? 2'd0 : state_q;

`ifdef CPRV_HAZARD_PERF_EN
    logic lu_entry;

    assign lu_entry = !rst && (state_q == HZ_RUN) && (state_d == HZ_LU_HOLD);

    cprv_sat_counter #(.WIDTH(32)) u_stall_cnt (
        .clk    (clk),
        .rst    (rst),
        .inc_en (stall_id),
        .count  (stall_cycles)
    );

    cprv_sat_counter #(.WIDTH(16)) u_lu_cnt (
        .clk    (clk),
        .rst    (rst),
        .inc_en (lu_entry),
        .count  (lu_events)
    );
`endif

endmodule

// File: tb/tb_cprv_hazard_unit.sv
// Directed self-checking bench for cprv_hazard_unit; counter checks are built
// when CPRV_HAZARD_PERF_EN is defined.
module tb_cprv_hazard_unit;
    import cprv_hazard_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       valid_id;
    logic [4:0] rs1_addr_id, rs2_addr_id;
    logic       rs1_used_id, rs2_used_id;
    logic [6:0] opcode_ex;
    logic [4:0] rd_addr_ex;
    logic       rd_en_ex;
    logic [6:0] opcode_mem;
    logic       dmem_ready;
    logic       stall_if, stall_id, stall_ex, stall_mem, bubble_ex;
    logic [1:0] hz_state;
`ifdef CPRV_HAZARD_PERF_EN
    logic [31:0] stall_cycles;
    logic [15:0] lu_events;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    wire [4:0] outs = {stall_if, stall_id, stall_ex, stall_mem, bubble_ex};

    localparam logic [4:0] O_NONE   = 5'b00000;
    localparam logic [4:0] O_BUBBLE = 5'b11001;
    localparam logic [4:0] O_FREEZE = 5'b11110;

    cprv_hazard_unit #(.DATA_WIDTH(64)) dut (
        .clk         (clk),
        .rst         (rst),
        .valid_id    (valid_id),
        .rs1_addr_id (rs1_addr_id),
        .rs2_addr_id (rs2_addr_id),
        .rs1_used_id (rs1_used_id),
        .rs2_used_id (rs2_used_id),
        .opcode_ex   (opcode_ex),
        .rd_addr_ex  (rd_addr_ex),
        .rd_en_ex    (rd_en_ex),
        .opcode_mem  (opcode_mem),
        .dmem_ready  (dmem_ready),
        .stall_if    (stall_if),
        .stall_id    (stall_id),
        .stall_ex    (stall_ex),
        .stall_mem   (stall_mem),
        .bubble_ex   (bubble_ex),
        .hz_state    (hz_state)
`ifdef CPRV_HAZARD_PERF_EN
        ,
        .stall_cycles(stall_cycles),
        .lu_events   (lu_events)
`endif
    );

    always #5 clk = ~clk;

    // Inputs change 1 ns after a rising edge; outputs are sampled 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        valid_id    = 1'b0;
        rs1_addr_id = 5'd0;
        rs2_addr_id = 5'd0;
        rs1_used_id = 1'b0;
        rs2_used_id = 1'b0;
        opcode_ex   = OP;
        rd_addr_ex  = 5'd0;
        rd_en_ex    = 1'b0;
        opcode_mem  = OP;
        dmem_ready  = 1'b1;
    endtask

    task automatic load_use_rs1(input logic [4:0] r);
        valid_id    = 1'b1;
        rs1_addr_id = r;
        rs1_used_id = 1'b1;
        opcode_ex   = LOAD;
        rd_addr_ex  = r;
        rd_en_ex    = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        load_use_rs1(5'd5);
        opcode_mem = LOAD;
        dmem_ready = 1'b0;
        #1;
        n_checks++;
        if (outs !== O_NONE || hz_state !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_comb: outs=%b hz=%0d want outs=%b hz=0", outs, hz_state, O_NONE);
        end
        step();
        n_checks++;
        if (outs !== O_NONE || hz_state !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_held: outs=%b hz=%0d want outs=%b hz=0", outs, hz_state, O_NONE);
        end
        rst = 1'b0;
        idle_inputs();
        #1;
        n_checks++;
        if (outs !== O_NONE || hz_state !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_release: outs=%b hz=%0d want outs=%b hz=0", outs, hz_state, O_NONE);
        end
`ifdef CPRV_HAZARD_PERF_EN
        n_checks++;
        if (stall_cycles !== 32'd0 || lu_events !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_counters: stall_cycles=%0d lu_events=%0d want 0 0", stall_cycles, lu_events);
        end
`endif
    endtask

    task automatic test_load_use();
        logic [4:0] exp_o [3] = '{O_BUBBLE, O_BUBBLE, O_NONE};
        logic [1:0] exp_s [3] = '{2'd0, 2'd1, 2'd0};
        do_reset();
        load_use_rs1(5'd5);
        for (int i = 0; i < 3; i++) begin
            if (i == 1) opcode_ex = OP_IMM;
            #1;
            n_checks++;
            if (outs !== exp_o[i] || hz_state !== exp_s[i]) begin
                n_fail++;
                $display("FAIL load_use_c%0d: outs=%b hz=%0d want outs=%b hz=%0d", i, outs, hz_state, exp_o[i], exp_s[i]);
            end
            step();
        end
`ifdef CPRV_HAZARD_PERF_EN
        n_checks++;
        if (lu_events !== 16'd1 || stall_cycles !== 32'd2) begin
            n_fail++;
            $display("FAIL load_use_counters: lu_events=%0d stall_cycles=%0d want 1 2", lu_events, stall_cycles);
        end
`endif
    endtask

    task automatic test_no_match();
        // pattern: 0 x0 dest, 1 unused rs2, 2 ID invalid, 3 rd_en low, 4 non-load in EX, 5 rs2 hit
        logic [4:0] exp_o [6] = '{O_NONE, O_NONE, O_NONE, O_NONE, O_NONE, O_BUBBLE};
        for (int p = 0; p < 6; p++) begin
            do_reset();
            valid_id    = 1'b1;
            opcode_ex   = LOAD;
            rd_en_ex    = 1'b1;
            rd_addr_ex  = 5'd7;
            rs1_addr_id = 5'd3;
            rs1_used_id = 1'b1;
            rs2_addr_id = 5'd7;
            rs2_used_id = 1'b1;
            case (p)
                0: begin rd_addr_ex = 5'd0; rs1_addr_id = 5'd0; rs2_addr_id = 5'd0; end
                1: rs2_used_id = 1'b0;
                2: valid_id = 1'b0;
                3: rd_en_ex = 1'b0;
                4: opcode_ex = OP;
                default: ;
            endcase
            for (int c = 0; c < 2; c++) begin
                #1;
                n_checks++;
                if (outs !== ((c == 0 || p != 5) ? exp_o[p] : O_BUBBLE)) begin
                    n_fail++;
                    $display("FAIL no_match_p%0d_c%0d: outs=%b want %b", p, c, outs, (c == 0 || p != 5) ? exp_o[p] : O_BUBBLE);
                end
                step();
            end
        end
    endtask

    task automatic test_lu_mem_wait();
        logic [4:0] exp_o [6] = '{O_BUBBLE, O_FREEZE, O_FREEZE, O_FREEZE, O_BUBBLE, O_NONE};
        logic [1:0] exp_s [6] = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd0};
        do_reset();
        load_use_rs1(5'd9);
        for (int i = 0; i < 6; i++) begin
            if (i == 1) begin opcode_ex = OP_IMM; opcode_mem = LOAD; dmem_ready = 1'b0; end
            if (i == 4) dmem_ready = 1'b1;
            if (i == 5) opcode_mem = OP;
            #1;
            n_checks++;
            if (outs !== exp_o[i] || hz_state !== exp_s[i]) begin
                n_fail++;
                $display("FAIL lu_mem_wait_c%0d: outs=%b hz=%0d want outs=%b hz=%0d", i, outs, hz_state, exp_o[i], exp_s[i]);
            end
            step();
        end
`ifdef CPRV_HAZARD_PERF_EN
        n_checks++;
        if (stall_cycles !== 32'd5 || lu_events !== 16'd1) begin
            n_fail++;
            $display("FAIL lu_mem_wait_counters: stall_cycles=%0d lu_events=%0d want 5 1", stall_cycles, lu_events);
        end
`endif
    endtask

    task automatic test_store_freeze();
        logic [4:0] exp_o [6] = '{O_FREEZE, O_FREEZE, O_FREEZE, O_FREEZE, O_NONE, O_NONE};
        logic [1:0] exp_s [6] = '{2'd0, 2'd2, 2'd2, 2'd2, 2'd2, 2'd0};
        do_reset();
        opcode_mem = STORE;
        dmem_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i == 4) dmem_ready = 1'b1;
            if (i == 5) opcode_mem = OP;
            #1;
            n_checks++;
            if (outs !== exp_o[i] || hz_state !== exp_s[i]) begin
                n_fail++;
                $display("FAIL store_freeze_c%0d: outs=%b hz=%0d want outs=%b hz=%0d", i, outs, hz_state, exp_o[i], exp_s[i]);
            end
            step();
        end
`ifdef CPRV_HAZARD_PERF_EN
        n_checks++;
        if (stall_cycles !== 32'd4 || lu_events !== 16'd0) begin
            n_fail++;
            $display("FAIL store_freeze_counters: stall_cycles=%0d lu_events=%0d want 4 0", stall_cycles, lu_events);
        end
`endif
    endtask

    task automatic test_back_to_back();
        // freeze, then a load-use hit in the cycle memory completes
        logic [4:0] exp_o [5] = '{O_FREEZE, O_FREEZE, O_BUBBLE, O_BUBBLE, O_NONE};
        logic [1:0] exp_s [5] = '{2'd0, 2'd2, 2'd2, 2'd1, 2'd0};
        do_reset();
        opcode_mem = LOAD;
        dmem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin dmem_ready = 1'b1; load_use_rs1(5'd12); end
            if (i == 3) begin opcode_ex = OP_IMM; opcode_mem = OP; end
            #1;
            n_checks++;
            if (outs !== exp_o[i] || hz_state !== exp_s[i]) begin
                n_fail++;
                $display("FAIL back_to_back_c%0d: outs=%b hz=%0d want outs=%b hz=%0d", i, outs, hz_state, exp_o[i], exp_s[i]);
            end
            step();
        end
    endtask

    task automatic test_reset_in_hold();
        do_reset();
        load_use_rs1(5'd5);
        step();
        rst = 1'b1;
        #1;
        n_checks++;
        if (outs !== O_NONE || hz_state !== 2'd0) begin
            n_fail++;
            $display("FAIL rst_in_hold_comb: outs=%b hz=%0d want outs=%b hz=0", outs, hz_state, O_NONE);
        end
        step();
        rst = 1'b0;
        idle_inputs();
        #1;
        n_checks++;
        if (outs !== O_NONE || hz_state !== 2'd0) begin
            n_fail++;
            $display("FAIL rst_in_hold_after: outs=%b hz=%0d want outs=%b hz=0", outs, hz_state, O_NONE);
        end
`ifdef CPRV_HAZARD_PERF_EN
        n_checks++;
        if (stall_cycles !== 32'd0 || lu_events !== 16'd0) begin
            n_fail++;
            $display("FAIL rst_in_hold_counters: stall_cycles=%0d lu_events=%0d want 0 0", stall_cycles, lu_events);
        end
`endif
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_load_use();
        test_no_match();
        test_lu_mem_wait();
        test_store_freeze();
        test_back_to_back();
        test_reset_in_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
